// File: rtl/croc_pkg.sv
// Shared SoC types: subordinate-side OBI channels, regbus channels and the
// register-bridge constants and FSM encoding.
package croc_pkg;

  localparam int unsigned SbrIdWidth   = 4;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned StrbWidth    = DataWidth / 8;

  typedef struct packed {
    int unsigned IdWidth;
    logic        UseRReady;
    logic        CombGnt;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{IdWidth: SbrIdWidth, UseRReady: 1'b0, CombGnt: 1'b0};

  typedef struct packed {
    logic [AddrWidth-1:0]  addr;
    logic                  we;
    logic [StrbWidth-1:0]  be;
    logic [DataWidth-1:0]  wdata;
    logic [SbrIdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0]  rdata;
    logic [SbrIdWidth-1:0] rid;
    logic                  err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

  localparam int unsigned RegBridgeTimeoutCycles = 256;
  localparam logic [31:0] RegBridgeErrData       = 32'hBADC_AB1E;

  typedef enum logic [1:0] {RbIdle, RbAccess, RbResp} reg_bridge_state_e;

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate to regbus manager bridge: one transaction in flight,
// ID echo on the response, and a timeout that turns a hung slave into an error.
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg        = SbrObiCfg,
  parameter type         obi_req_t     = sbr_obi_req_t,
  parameter type         obi_rsp_t     = sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = RegBridgeTimeoutCycles,
  parameter logic [31:0] ErrData       = RegBridgeErrData
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     busy_o
);

  localparam int unsigned IdWidth  = ObiCfg.IdWidth;
  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CntSat  = CntWidth'(TimeoutCycles);

  reg_bridge_state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic [StrbWidth-1:0] be_q;
  logic [IdWidth-1:0]   aid_q;
  logic                 we_q;
  logic                 err_q;
  logic [CntWidth-1:0]  cnt_q;

  logic gnt;
  logic timeout;
  logic capture;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RbIdle;
    else         state_q <= state_d;
  end

  // Next state; a new request can only be accepted while no access is pending
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    timeout = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      RbIdle: begin
        gnt = obi_req_i.req;
        if (gnt) state_d = RbAccess;
      end
      RbAccess: begin
        timeout = (TimeoutCycles != 0) && !reg_rsp_i.ready && (cnt_q == CntLast);
        capture = reg_rsp_i.ready || timeout;
        if (capture) state_d = RbResp;
      end
      RbResp: begin
        gnt     = obi_req_i.req;
        state_d = gnt ? RbAccess : RbIdle;
      end
      default: state_d = RbIdle;
    endcase
  end

  // Outputs decoded from the state register and the latched transaction
  always_comb begin
    obi_rsp_o     = '0;
    reg_req_o     = '0;
    busy_o        = (state_q != RbIdle);
    obi_rsp_o.gnt = gnt;
    unique case (state_q)
      RbAccess: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = we_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = we_q ? be_q : '0;
      end
      RbResp: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = aid_q;
        obi_rsp_o.r.err   = err_q;
      end
      default: ;
    endcase
  end

  // Request latch on grant, response capture on ready or timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      aid_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (gnt) begin
        addr_q  <= obi_req_i.a.addr;
        wdata_q <= obi_req_i.a.wdata;
        be_q    <= obi_req_i.a.be;
        aid_q   <= IdWidth'(obi_req_i.a.aid);
        we_q    <= obi_req_i.a.we;
      end
      if (capture) begin
        if (we_q)         rdata_q <= '0;
        else if (timeout) rdata_q <= ErrData;
        else              rdata_q <= reg_rsp_i.rdata;
        err_q <= timeout ? 1'b1 : reg_rsp_i.error;
      end
    end
  end

  // Saturating wait counter, cleared whenever an access starts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (gnt) begin
      cnt_q <= '0;
    end else if ((state_q == RbAccess) && !reg_rsp_i.ready && (cnt_q != CntSat)) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Scoreboard bench for croc_obi_reg_bridge: stimulus pushes expected responses,
// a monitor pops and compares them whenever rvalid is seen.
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  localparam int unsigned Timeout = 8;
  localparam logic [31:0] ErrVal  = 32'hBADC_AB1E;

  logic         clk = 1'b0;
  logic         rst_n;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp = '0;
  logic         busy;

  croc_obi_reg_bridge #(
    .TimeoutCycles(Timeout)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Regbus slave model: ready after slv_wait stall cycles unless slv_never
  int          vcnt      = 0;
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  bit          slv_never = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reg_req.valid) vcnt = vcnt + 1;
    else               vcnt = 0;
    reg_rsp.ready = reg_req.valid && !slv_never && (vcnt > slv_wait);
    reg_rsp.rdata = reg_rsp.ready ? slv_rdata : 32'h0;
    reg_rsp.error = reg_rsp.ready && slv_err;
  end

  // Response monitor
  always @(negedge clk) begin
    if (obi_rsp.rvalid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rid 0x%0h with empty scoreboard (cycle %0d)",
                 obi_rsp.r.rid, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_rid",   64'(obi_rsp.r.rid),   64'(e.rid));
        chk("rsp_rdata", 64'(obi_rsp.r.rdata), 64'(e.rdata));
        chk("rsp_err",   64'(obi_rsp.r.err),   64'(e.err));
        chk("rsp_cycle", 64'(cyc),             64'(e.at));
      end
    end
  end

  // One isolated transaction; checks grant, regbus fields each valid cycle and valid duration
  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] aid,
                         input int wt, input logic [31:0] rd, input logic se, input bit never);
    int          t;
    int          nv = 0;
    int          n  = 0;
    int          nacc;
    bit          to;
    logic [31:0] erd;
    logic        eerr;
    slv_wait  = wt;
    slv_rdata = rd;
    slv_err   = se;
    slv_never = never;
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = addr;
    obi_req.a.wdata = wdata;
    obi_req.a.be    = be;
    obi_req.a.aid   = aid;
    #1;
    chk({tag, "_gnt"}, 64'(obi_rsp.gnt), 64'd1);
    t    = cyc;
    to   = never || (wt >= int'(Timeout));
    nacc = to ? int'(Timeout) : wt + 1;
    erd  = we ? 32'h0 : (to ? ErrVal : rd);
    eerr = to ? 1'b1 : se;
    sbq.push_back('{aid, erd, eerr, t + 1 + nacc});
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
    obi_req.a   = ~obi_req.a;
    #1;
    chk({tag, "_gnt_access"}, 64'(obi_rsp.gnt), 64'd0);
    while (busy && n < 40) begin
      if (reg_req.valid) begin
        nv++;
        chk({tag, "_addr"},  64'(reg_req.addr),  64'(addr));
        chk({tag, "_write"}, 64'(reg_req.write), 64'(we));
        chk({tag, "_wdata"}, 64'(reg_req.wdata), 64'(wdata));
        chk({tag, "_wstrb"}, 64'(reg_req.wstrb), 64'(we ? be : 4'b0000));
      end
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, "_valid_cycles"}, 64'(nv), 64'(nacc));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    rst_n   = 1'b0;
    obi_req = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_obi_rsp",  64'(obi_rsp),        64'd0);
    chk("rst_reg_req",  64'(reg_req == '0),  64'd1);
    chk("rst_busy",     64'(busy),           64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run_txn("rd0",  1'b0, 32'h0300_0004, 32'h0,          4'hF,    4'd3, 0, 32'h1234_5678, 1'b0, 1'b0);
    run_txn("wr3",  1'b1, 32'h0300_0008, 32'hA5A5_0001, 4'b0011, 4'd1, 3, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back: request held across four grants
    slv_wait  = 0;
    slv_rdata = 32'h0BB0_0000;
    slv_err   = 1'b0;
    slv_never = 1'b0;
    obi_req.req    = 1'b1;
    obi_req.a.we   = 1'b0;
    obi_req.a.addr = 32'h0300_0010;
    obi_req.a.aid  = 4'd0;
    #1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_gnt",       64'(obi_rsp.gnt), 64'd1);
      chk("b2b_gnt_cycle", 64'(cyc),         64'(t0 + 2 * i));
      if (i > 0) chk("b2b_overlap_rvalid", 64'(obi_rsp.rvalid), 64'd1);
      sbq.push_back('{4'(i), 32'h0BB0_0000, 1'b0, cyc + 2});
      @(posedge clk);
      #1;
      if (i < 3) obi_req.a.aid = 4'(i + 1);
      else       obi_req.req   = 1'b0;
      #1;
      chk("b2b_gnt_access", 64'(obi_rsp.gnt), 64'd0);
      @(posedge clk);
      #2;
    end
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("b2b_idle", 64'(busy), 64'd0);

    run_txn("to_rd",    1'b0, 32'h0300_000C, 32'h0,          4'h0, 4'd7, 0, 32'h0,          1'b0, 1'b1);
    run_txn("after_to", 1'b0, 32'h0300_0000, 32'h0,          4'h0, 4'd2, 1, 32'h0000_00C3, 1'b0, 1'b0);
    run_txn("rdy_last", 1'b0, 32'h0300_0014, 32'h0,          4'h0, 4'd4, 7, 32'h7777_0008, 1'b0, 1'b0);
    run_txn("to_wr",    1'b1, 32'h0300_0018, 32'h1111_2222, 4'hF, 4'd5, 0, 32'h0,          1'b0, 1'b1);
    run_txn("slv_err",  1'b0, 32'h0300_001C, 32'h0,          4'h0, 4'd8, 0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset during the second stalled ACCESS cycle: no response may follow
    slv_wait  = 5;
    slv_never = 1'b0;
    obi_req.req    = 1'b1;
    obi_req.a.we   = 1'b0;
    obi_req.a.addr = 32'h0300_0020;
    obi_req.a.aid  = 4'd6;
    #1;
    chk("rst_txn_gnt", 64'(obi_rsp.gnt), 64'd1);
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_txn_valid_before", 64'(reg_req.valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid",  64'(reg_req.valid),  64'd0);
    chk("rst_async_busy",   64'(busy),           64'd0);
    chk("rst_async_rvalid", 64'(obi_rsp.rvalid), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    run_txn("post_rst", 1'b0, 32'h0300_0024, 32'h0, 4'h0, 4'd9, 0, 32'h5555_AAAA, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/croc_obi_reg_bridge.md
Name: croc_obi_reg_bridge

Overview:
OBI subordinate that terminates one crossbar output and drives a register-interface (regbus) manager port. Its requests and responses use the package subordinate-side OBI types (SbrObiCfg, sbr_obi_req_t/sbr_obi_rsp_t). It sits between the crossbar peripheral output and regbus peripherals (SoC control, GPIO, timer).
It handles one transaction at a time, returns the OBI response with the captured ID, and converts a hung regbus slave into an OBI error through a timeout.

Parameters:
- ObiCfg, croc_pkg::SbrObiCfg: OBI configuration. UseRReady=0 and CombGnt=0 are required.
- obi_req_t, croc_pkg::sbr_obi_req_t: OBI request type.
- obi_rsp_t, croc_pkg::sbr_obi_rsp_t: OBI response type.
- reg_req_t, croc_pkg::reg_req_t: regbus request type.
- reg_rsp_t, croc_pkg::reg_rsp_t: regbus response type.
- TimeoutCycles, 256: maximum cycles with reg valid high and no ready. 0 disables the timeout.
- ErrData, 32'hBADC_AB1E: rdata returned on a timed-out read.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  obi_req_t  OBI request from the crossbar
- obi_rsp_o  out  obi_rsp_t  OBI response to the crossbar
- reg_req_o  out  reg_req_t  regbus request
- reg_rsp_i  in  reg_rsp_t  regbus response
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: FSM in IDLE. obi_rsp_o is all zero (gnt=0, rvalid=0, rdata=0, rid=0, err=0). reg_req_o is all zero. Timeout counter is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - gnt = obi_req_i.req, combinational. Allowed with CombGnt=0 because gnt depends only on req.
  - On req: latch addr, we, be, wdata, aid, then go to ACCESS.
- ACCESS:
  - reg_req_o.valid=1, addr=latched addr, write=latched we, wdata=latched wdata.
  - wstrb=latched be on writes, 4'b0 on reads.
  - Request fields are held stable until ready.
  - On reg_rsp_i.ready: capture rdata (forced to 0 on writes) and err=reg_rsp_i.error, go to RESP.
  - Timeout counter increments each ACCESS cycle without ready. If it reaches TimeoutCycles-1 without ready, go to RESP with err=1 and rdata=ErrData (0 on writes); valid drops on the next cycle.
  - ready and the timeout firing in the same cycle: ready wins, normal response.
- RESP:
  - rvalid=1 for exactly one cycle with rid=latched aid and the captured rdata/err. No rready, so the response is never stalled.
  - gnt = obi_req_i.req in the same cycle. If granted, latch the new request and go to ACCESS; otherwise go to IDLE.
  - Counter clears on every ACCESS entry.
- gnt is 0 in ACCESS.
- rvalid is never asserted in the grant cycle (min 1-cycle gap, per CombGnt=0).
- Latency: grant at T, reg valid at T+1, zero-wait ready at T+1, rvalid at T+2. Each regbus wait state adds one cycle.
- Throughput: back-to-back requests complete every 2 cycles with zero-wait slaves.
- Ignored inputs: reg_rsp_i.ready while not in ACCESS; any obi_req_i change after grant.
- Reset mid-transaction: reg valid and rvalid drop immediately (async), the latched request is discarded, and no response is issued.
- Widths: addr is 32 bits, passed unmodified (no alignment masking). rid width = ObiCfg.IdWidth. The counter is clog2(TimeoutCycles+1) bits and saturates.

Decomposition:
- Add to croc_pkg:
  - RegBridgeTimeoutCycles = 256
  - RegBridgeErrData = 32'hBADC_AB1E
  - typedef enum logic [1:0] {RbIdle, RbAccess, RbResp} reg_bridge_state_e
- No sub-module: the FSM, latch registers and counter stay in one module.

Test Plan:
- Zero-wait read: OBI read, addr 0x0300_0004, aid 3; slave ready in first valid cycle with rdata 0x1234_5678 → gnt at T, reg valid at T+1 with wstrb 0, rvalid at T+2 with rdata 0x1234_5678, rid 3, err 0.
- Write with wait states: OBI write, wdata 0xA5A5_0001, be 4'b0011; slave ready after 3 wait cycles → write=1, wstrb=0011, wdata held stable 4 cycles, rvalid 5 cycles after grant, rdata 0, err 0.
- Back-to-back: req held for 4 transactions with distinct aids 0..3, zero-wait slave → grants at T, T+2, T+4, T+6; rvalids at T+2, T+4, T+6, T+8 with rids in order; gnt and rvalid coincide at T+2, T+4, T+6.
- Timeout: TimeoutCycles=8, slave never ready, read → valid high exactly 8 cycles, then rvalid with err=1, rdata 0xBADC_AB1E; next request is served normally. Repeat with ready arriving in the 8th cycle → normal response, err=0.
- Slave error: ready with error=1 and rdata 0xDEAD_BEEF → rvalid with err=1, rdata 0xDEAD_BEEF.
- Reset mid-ACCESS: assert rst_ni low in the 2nd wait cycle → reg valid and busy_o low asynchronously, no rvalid. After release, a new read completes in 2 cycles with the correct rid.
